// File: rtl/alu_result_collector.sv
// ALU result collector: FWFT FIFO of ALU results with parity checking
// and saturating statistics counters for invalid and parity-error entries.
module alu_result_collector #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*width:0]          in_out,
    input  logic                      in_odd_parity,
    input  logic                      in_invalid,
    input  logic [2:0]                in_opcode,
    input  logic                      in_bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*width:0]          out_data,
    output logic                      out_invalid,
    output logic                      out_parity_err,
    input  logic                      clr_stats,
    output logic [$clog2(depth):0]    count,
    output logic [7:0]                invalid_cnt,
    output logic [7:0]                parity_err_cnt
);

    localparam int DW = 2 * width + 1;
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    inv_cnt_q, inv_cnt_d;
    logic [7:0]    perr_cnt_q, perr_cnt_d;

    logic [DW-1:0] mem_data_q [depth];
    logic [DW-1:0] mem_data_d [depth];
    logic          mem_inv_q  [depth];
    logic          mem_inv_d  [depth];
    logic          mem_perr_q [depth];
    logic          mem_perr_d [depth];

    logic push;
    logic pop;
    logic exp_par;
    logic par_err;

    // Handshake, parity check and head-entry presentation
    always_comb begin
        in_ready  = (count_q < FULL);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        exp_par   = 1'b0;
        if (!in_bypass && (in_opcode >= 3'd2) && (in_opcode <= 3'd5)) begin
            exp_par = ~(^in_out);
        end
        par_err        = (in_odd_parity != exp_par);
        out_data       = out_valid ? mem_data_q[rd_ptr_q] : '0;
        out_invalid    = out_valid ? mem_inv_q[rd_ptr_q] : 1'b0;
        out_parity_err = out_valid ? mem_perr_q[rd_ptr_q] : 1'b0;
        count          = count_q;
        invalid_cnt    = inv_cnt_q;
        parity_err_cnt = perr_cnt_q;
    end

    // Next-state for pointers, occupancy and statistics
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inv_cnt_d  = inv_cnt_q;
        perr_cnt_d = perr_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr_stats) begin
            inv_cnt_d  = '0;
            perr_cnt_d = '0;
        end else begin
            if (push && in_invalid && (inv_cnt_q != 8'hFF)) begin
                inv_cnt_d = inv_cnt_q + 8'd1;
            end
            if (push && par_err && (perr_cnt_q != 8'hFF)) begin
                perr_cnt_d = perr_cnt_q + 8'd1;
            end
        end
    end

    // Next-state for entry storage: write slot at the write pointer
    always_comb begin
        mem_data_d = mem_data_q;
        mem_inv_d  = mem_inv_q;
        mem_perr_d = mem_perr_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = in_out;
            mem_inv_d[wr_ptr_q]  = in_invalid;
            mem_perr_d[wr_ptr_q] = par_err;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inv_cnt_q  <= '0;
            perr_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inv_cnt_q  <= inv_cnt_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    // Entry storage; contents are only observed through count, so no reset
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_inv_q  <= mem_inv_d;
        mem_perr_q <= mem_perr_d;
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector (width=4, depth=4).
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_alu_result_collector;

    localparam int DEPTH = 4;

    typedef struct {
        logic [8:0] data;
        logic       inv;
        logic       perr;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_out;
    logic       in_odd_parity;
    logic       in_invalid;
    logic [2:0] in_opcode;
    logic       in_bypass;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic       out_invalid;
    logic       out_parity_err;
    logic       clr_stats;
    logic [2:0] count;
    logic [7:0] invalid_cnt;
    logic [7:0] parity_err_cnt;

    logic   exp_perr;
    entry_t sb[$];
    int     mcount = 0;
    int     minv = 0;
    int     mperr = 0;
    int     checks = 0;
    int     errors = 0;
    logic   m_push;
    logic   m_pop;

    alu_result_collector #(.width(4), .depth(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_out        (in_out),
        .in_odd_parity (in_odd_parity),
        .in_invalid    (in_invalid),
        .in_opcode     (in_opcode),
        .in_bypass     (in_bypass),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_invalid   (out_invalid),
        .out_parity_err(out_parity_err),
        .clr_stats     (clr_stats),
        .count         (count),
        .invalid_cnt   (invalid_cnt),
        .parity_err_cnt(parity_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    assign m_push = in_valid && (mcount < DEPTH);
    assign m_pop  = out_ready && (mcount != 0);

    // Reference occupancy/statistics model and scoreboard producer
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            mcount <= 0;
            minv   <= 0;
            mperr  <= 0;
        end else begin
            if (m_push) begin
                sb.push_back('{in_out, in_invalid, exp_perr});
            end
            mcount <= mcount + int'(m_push) - int'(m_pop);
            if (clr_stats) begin
                minv  <= 0;
                mperr <= 0;
            end else begin
                if (m_push && in_invalid && minv != 255) minv <= minv + 1;
                if (m_push && exp_perr && mperr != 255) mperr <= mperr + 1;
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on transfer
    always @(negedge clk) begin
        entry_t e;
        if (!rst) begin
            chk("count", int'(count), mcount);
            chk("out_valid", int'(out_valid), int'(mcount != 0));
            chk("in_ready", int'(in_ready), int'(mcount < DEPTH));
            chk("invalid_cnt", int'(invalid_cnt), minv);
            chk("parity_err_cnt", int'(parity_err_cnt), mperr);
            if (mcount == 0) begin
                chk("idle_data", int'(out_data), 0);
                chk("idle_inv", int'(out_invalid), 0);
                chk("idle_perr", int'(out_parity_err), 0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("out_invalid", int'(out_invalid), int'(e.inv));
                    chk("out_parity_err", int'(out_parity_err), int'(e.perr));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] op, input logic byp,
                        input logic [8:0] val, input logic par,
                        input logic inv, input logic perr);
        in_valid      = 1'b1;
        in_opcode     = op;
        in_bypass     = byp;
        in_out        = val;
        in_odd_parity = par;
        in_invalid    = inv;
        exp_perr      = perr;
        cyc(1);
        in_valid      = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_out        = '0;
        in_odd_parity = 1'b0;
        in_invalid    = 1'b0;
        in_opcode     = '0;
        in_bypass     = 1'b0;
        out_ready     = 1'b0;
        clr_stats     = 1'b0;
        exp_perr      = 1'b0;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        cyc(1);

        // Good parity on opcode 010: 7 has xor 1, expected 0
        push(3'b010, 1'b0, 9'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 7);
        chk("lat_perr", int'(out_parity_err), 0);
        chk("lat_pcnt", int'(parity_err_cnt), 0);
        cyc(1);

        // Parity errors: 6 has xor 0 so expected 1; opcode 000 expects 0
        out_ready = 1'b1;
        push(3'b011, 1'b0, 9'd6, 1'b0, 1'b0, 1'b1);
        push(3'b000, 1'b0, 9'd6, 1'b1, 1'b0, 1'b1);
        push(3'b100, 1'b1, 9'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pcnt_two", int'(parity_err_cnt), 2);
        cyc(4);

        // Fill to full; fifth push (invalid, bad parity) must be ignored
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(3'b000, 1'b0, 9'(i), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_count", int'(count), 4);
        cyc(1);
        push(3'b000, 1'b0, 9'd5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("ign_icnt", int'(invalid_cnt), 0);
        chk("ign_pcnt", int'(parity_err_cnt), 2);
        cyc(1);
        out_ready = 1'b1;
        cyc(6);
        chk("drain_count", int'(count), 0);

        // Steady state at count=2 with simultaneous push/pop across wraps
        out_ready = 1'b0;
        push(3'b000, 1'b0, 9'd10, 1'b0, 1'b0, 1'b0);
        push(3'b000, 1'b0, 9'd11, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(3'b000, 1'b0, 9'(20 + i), 1'b0, 1'b0, 1'b0);
            chk("steady_count", int'(count), 2);
        end
        cyc(4);

        // Invalid counter saturation then clear beating a same-cycle push
        for (int i = 0; i < 300; i++) begin
            push(3'b000, 1'b0, 9'(i), 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        chk("icnt_sat", int'(invalid_cnt), 255);
        cyc(1);
        clr_stats = 1'b1;
        push(3'b000, 1'b0, 9'd99, 1'b0, 1'b1, 1'b0);
        clr_stats = 1'b0;
        @(negedge clk);
        chk("icnt_clr", int'(invalid_cnt), 0);
        chk("pcnt_clr", int'(parity_err_cnt), 0);
        cyc(3);

        // Mid-operation reset discards three held entries
        out_ready = 1'b0;
        push(3'b011, 1'b0, 9'd6, 1'b0, 1'b1, 1'b1);
        push(3'b000, 1'b0, 9'd2, 1'b0, 1'b1, 1'b0);
        push(3'b000, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", int'(count), 3);
        cyc(1);
        rst = 1'b1;
        in_valid = 1'b1;
        cyc(1);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_ready", int'(in_ready), 1);
        chk("post_rst_icnt", int'(invalid_cnt), 0);
        chk("post_rst_pcnt", int'(parity_err_cnt), 0);
        cyc(3);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter width, default 4: ALU operand width minus one; result bus is 2*width+1 bits.
REQ-002 Parameter depth, default 4: FIFO entries, power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream ALU result valid.
REQ-006 in_ready  out  1  collector can accept an entry this cycle.
REQ-007 in_out  in  2*width+1  ALU out.
REQ-008 in_odd_parity  in  1  ALU odd_parity.
REQ-009 in_invalid  in  1  ALU invalid.
REQ-010 in_opcode  in  3  opcode applied to the ALU for this result.
REQ-011 in_bypass  in  1  bypass_A OR bypass_B applied to the ALU for this result.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_ready  in  1  downstream accepts head entry.
REQ-014 out_data  out  2*width+1  head entry result.
REQ-015 out_invalid  out  1  head entry invalid flag.
REQ-016 out_parity_err  out  1  head entry parity-check failure.
REQ-017 clr_stats  in  1  synchronous clear of statistics counters only.
REQ-018 count  out  log2(depth)+1  entries held.
REQ-019 invalid_cnt  out  8  accepted entries with in_invalid=1, saturating.
REQ-020 parity_err_cnt  out  8  accepted entries failing parity check, saturating.

Function
REQ-021 Push occurs when in_valid AND in_ready; pop occurs when out_valid AND out_ready.
REQ-022 in_ready SHALL equal (count < depth), combinational from registered count; no push when full even if a pop occurs that cycle.
REQ-023 out_valid SHALL equal (count != 0); out_data/out_invalid/out_parity_err SHALL show the head entry (first-word fall-through, registered storage).
REQ-024 Latency: an entry pushed into an empty FIFO in cycle N SHALL appear on out_valid in cycle N+1.
REQ-025 Simultaneous push and pop with 0<count<depth: count unchanged, order preserved.
REQ-026 Read and write pointers SHALL wrap modulo depth; count SHALL never exceed depth nor go below 0.
REQ-027 Expected parity: if in_bypass=0 and in_opcode in 010..101, expected = NOT(XOR-reduce in_out); otherwise expected = 0.
REQ-028 Parity error for an entry SHALL be (in_odd_parity != expected), computed at push and stored with the entry.
REQ-029 On push, invalid_cnt SHALL increment if in_invalid=1 and parity_err_cnt SHALL increment if parity error, each saturating at 255.
REQ-030 clr_stats=1 SHALL zero both counters next cycle and take priority over a same-cycle increment; FIFO contents unaffected.
REQ-031 Inputs presented while in_ready=0 SHALL be ignored, with no counter update.

Reset
REQ-032 rst=1 SHALL, at the next edge, set pointers and count to 0, out_valid=0, in_ready=1 the following cycle, invalid_cnt=0, parity_err_cnt=0; rst has priority over all other inputs.
REQ-033 While count=0, out_data, out_invalid and out_parity_err SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all held entries; no pop is reported for discarded entries.

Verification (width=4, depth=4)
REQ-035 Push opcode 010, in_bypass=0, in_out=9'd7, in_odd_parity=0 -> next cycle out_valid=1, out_data=7, out_parity_err=0, parity_err_cnt=0.
REQ-036 Push opcode 011, in_out=9'd6, in_odd_parity=0 -> out_parity_err=1, parity_err_cnt=1; push opcode 000, in_odd_parity=1 -> parity_err_cnt=2.
REQ-037 out_ready=0, push 5 entries with values 1..5 on consecutive cycles -> in_ready=0 after 4th, count=4, 5th ignored; then out_ready=1 -> pops 1,2,3,4 in order.
REQ-038 count=2, push and pop same cycle for 10 cycles -> count stays 2, outputs in push order across pointer wrap.
REQ-039 Push 300 entries with in_invalid=1 -> invalid_cnt=255; clr_stats pulse coincident with push -> invalid_cnt=0.
REQ-040 count=3, assert rst one cycle -> count=0, out_valid=0, counters 0, in_ready=1 after release.
